milestone_fader: RTL and testbench
==================================

// Module: milestone_fader
// PURPOSE
//  Parametrised colour-gradient generator for addressable LED strips. Holds a
//  shift register of milestone colours, linearly interpolates between adjacent
//  milestones per LED and streams one channel byte per handshake to the serial
//  LED driver. A per-frame phase advance scrolls the gradient smoothly, and a
//  new milestone is shifted in every INTERP frames.
// PARAMETERS
//  LEDS      11  LEDs per frame (>=1)
//  INTERP    4   interpolation steps between milestones; power of two, >=2
//  CHANNELS  3   colour channels per LED (3=GRB, 4=GRBW); order ch0 first
//  COLOR_W   8   bits per channel
//  (local) K=$clog2(INTERP); MS=((LEDS+INTERP-2)>>K)+2 milestones stored
// PORTS
//  CLK          in   1                  system clock
//  RST_N        in   1                  async reset, active low
//  frame_start  in   1                  1-cycle pulse: render one frame
//  ms_wr_en     in   1                  load staging milestone
//  ms_wr_data   in   CHANNELS*COLOR_W   staging milestone; ch0 in LSBs
//  px_valid     out  1                  px_data valid
//  px_ready     in   1                  consumer accepts px_data
//  px_data      out  COLOR_W            current channel value
//  px_last      out  1                  marks final byte of frame
//  busy         out  1                  frame in progress
//  frame_done   out  1                  1-cycle pulse after final byte accepted
// BEHAVIOUR
//  Reset: px_valid=0, px_data=0, px_last=0, busy=0, frame_done=0, phase=0,
//   all milestones=0, staging=0, counters=0. Asserting RST_N low mid-frame
//   aborts immediately; no partial-frame resume.
//  FSM IDLE->LOAD->STREAM->ADVANCE->IDLE.
//   IDLE: frame_start -> LOAD. frame_start in any other state is ignored.
//   LOAD: 1 cycle; registers first byte; px_valid rises the cycle after LOAD,
//    i.e. 2 cycles after frame_start. busy=1 from LOAD until ADVANCE.
//   STREAM: byte transfers on px_valid&&px_ready. px_data/px_last stay stable
//    while px_valid&&!px_ready. Next byte is presented the cycle after a
//    transfer (zero bubbles at px_ready=1). Order: channel inner, LED outer.
//    px_last=1 on LED LEDS-1, channel CHANNELS-1. Its transfer -> ADVANCE.
//   ADVANCE: 1 cycle. px_valid=0, frame_done=1. phase<=(phase+1) mod INTERP.
//    On wrap to 0: milestones shift up one slot (ms[i]<=ms[i-1]) and ms[0]<=staging.
//    The staging register is retained, so it repeats if not rewritten.
//  ms_wr_en is accepted in any state. If it coincides with the ADVANCE shift,
//   the old staging value is shifted and the new value is latched for later.
//  Position p=led+phase (width to hold LEDS+INTERP-2); m=p>>K; i=p&(INTERP-1).
//   out=(ms[m][c]*(INTERP-i)+ms[m+1][c]*i)>>K, with intermediate width COLOR_W+K+1.
//   Truncates toward 0; i=0 gives ms[m] exactly; result never exceeds 2^COLOR_W-1.
//  Milestone contents never change during STREAM, so a frame is self-consistent.
// STRUCTURE
//  Shared include fader_defs.vh: FSM state encodings, clog2-derived width
//   localparam macros, channel-order constants reused by the LED driver.
//  Sub-module fader_lerp: combinational blend of one channel
//   (a,b,i -> out), parametrised COLOR_W and INTERP.
//  The top level holds the FSM, counters, milestone shift store, staging
//   register and output register.
// TESTING (LEDS=5, INTERP=4, CHANNELS=3, COLOR_W=8 unless stated)
//  1 Gradient: ms0=0x000000, ms1=0x404040, phase=0, px_ready=1 -> 15 bytes
//    00,00,00,10,10,10,20,20,20,30,30,30,40,40,40; px_last on byte 15 only.
//  2 Phase scroll: repeat frame -> LED0=10, LED3=40, LED4=40. After 4 frames,
//    phase=0 and staging 0xFFFFFF is shifted in: frame-5 LED0=FF.
//  3 Backpressure: drop px_ready for 3 cycles on byte 4 -> px_data=10 held
//    stable, no byte lost/duplicated, total 15 transfers, frame_done once.
//  4 Latency/throughput: frame_start at cycle t -> px_valid at t+2; ready
//    always 1 -> frame_done at t+2+15; frame_start at t+5 ignored.
//  5 Reset mid-frame: RST_N low after byte 7 -> outputs 0 asynchronously;
//    the next frame after release starts at LED0 with phase 0 and all bytes 00.
//  6 Params CHANNELS=4, INTERP=8, LEDS=1: 4 bytes per frame, px_last on byte 4;
//    the shift occurs every 8th frame; midpoint i=4 of 00/FF -> 7F.

Source files
------------

// File: rtl/milestone_fader_pkg.sv
// Shared types and width helpers for the milestone gradient fader.
package milestone_fader_pkg;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_STREAM  = 2'd2,
        ST_ADVANCE = 2'd3
    } state_t;

    // Channel order within one LED as seen on the serial stream.
    localparam int CH_G = 0;
    localparam int CH_R = 1;
    localparam int CH_B = 2;
    localparam int CH_W = 3;

    // Bits needed for a counter over n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/milestone_fader_lerp.sv
// Combinational linear blend of one colour channel between two milestones.
module milestone_fader_lerp #(
    parameter int COLOR_W = 8,
    parameter int INTERP  = 4,
    localparam int K      = $clog2(INTERP)
) (
    input  logic [COLOR_W-1:0] a,
    input  logic [COLOR_W-1:0] b,
    input  logic [K-1:0]       i,
    output logic [COLOR_W-1:0] y
);

    localparam int SW = COLOR_W + K + 1;
    localparam logic [K:0] FULL = (K + 1)'(INTERP);

    // Weighted sum of the two endpoints, truncated back to channel width.
    // The weights always add up to INTERP, so the shifted result can never
    // exceed the larger endpoint and needs no saturation.
    function automatic logic [COLOR_W-1:0] blend(
        input logic [COLOR_W-1:0] ca,
        input logic [COLOR_W-1:0] cb,
        input logic [K-1:0]       step
    );
        logic [K:0]    wa;
        logic [K:0]    wb;
        logic [SW-1:0] sum;
        wa  = FULL - {1'b0, step};
        wb  = {1'b0, step};
        sum = {{(K + 1){1'b0}}, ca} * {{COLOR_W{1'b0}}, wa}
            + {{(K + 1){1'b0}}, cb} * {{COLOR_W{1'b0}}, wb};
        return COLOR_W'(sum >> K);
    endfunction

    assign y = blend(a, b, i);

endmodule

// File: rtl/milestone_fader.sv
// Gradient generator: milestone shift store, per-LED interpolation and a
// byte-wide valid/ready stream towards the serial LED driver.
module milestone_fader
    import milestone_fader_pkg::*;
#(
    parameter int LEDS     = 11,
    parameter int INTERP   = 4,
    parameter int CHANNELS = 3,
    parameter int COLOR_W  = 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        frame_start,
    input  logic                        ms_wr_en,
    input  logic [CHANNELS*COLOR_W-1:0] ms_wr_data,
    output logic                        px_valid,
    input  logic                        px_ready,
    output logic [COLOR_W-1:0]          px_data,
    output logic                        px_last,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int K  = $clog2(INTERP);
    localparam int MS = ((LEDS + INTERP - 2) >> K) + 2;
    localparam int MW = cnt_w(MS);
    localparam int PW = cnt_w(LEDS + INTERP - 1);
    localparam int LW = cnt_w(LEDS);
    localparam int CW = cnt_w(CHANNELS);
    localparam int DW = CHANNELS * COLOR_W;

    localparam logic [LW-1:0] LED_LAST = LW'(LEDS - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);
    localparam logic [K-1:0]  PH_LAST  = K'(INTERP - 1);

    state_t          state;
    logic [K-1:0]    phase;
    logic [LW-1:0]   led_cnt;
    logic [CW-1:0]   ch_cnt;
    logic [DW-1:0]   staging;
    logic [DW-1:0]   ms [MS];

    logic [PW-1:0]      pos;
    logic [MW-1:0]      m_idx;
    logic [MW-1:0]      m1_idx;
    logic [COLOR_W-1:0] ch_a;
    logic [COLOR_W-1:0] ch_b;
    logic [COLOR_W-1:0] lerp_y;
    logic               at_last;

    // The counters always point at the byte to be registered next.
    assign pos     = PW'(led_cnt) + PW'(phase);
    assign m_idx   = MW'(pos >> K);
    assign m1_idx  = m_idx + 1'b1;
    assign ch_a    = ms[m_idx][ch_cnt*COLOR_W +: COLOR_W];
    assign ch_b    = ms[m1_idx][ch_cnt*COLOR_W +: COLOR_W];
    assign at_last = (led_cnt == LED_LAST) && (ch_cnt == CH_LAST);

    milestone_fader_lerp #(
        .COLOR_W (COLOR_W),
        .INTERP  (INTERP)
    ) u_lerp (
        .a (ch_a),
        .b (ch_b),
        .i (pos[K-1:0]),
        .y (lerp_y)
    );

    // Staging milestone: any write is taken immediately, in every state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            staging <= '0;
        end else if (ms_wr_en) begin
            staging <= ms_wr_data;
        end
    end

    // Milestone store shifts once per INTERP frames, at the end of the frame,
    // so its contents are frozen while a frame streams out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int j = 0; j < MS; j++) begin
                ms[j] <= '0;
            end
        end else if (state == ST_ADVANCE && phase == PH_LAST) begin
            ms[0] <= staging;
            for (int j = 1; j < MS; j++) begin
                ms[j] <= ms[j-1];
            end
        end
    end

    // Frame sequencer with registered stream outputs and byte counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            phase      <= '0;
            led_cnt    <= '0;
            ch_cnt     <= '0;
            px_valid   <= 1'b0;
            px_data    <= '0;
            px_last    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state   <= ST_LOAD;
                        busy    <= 1'b1;
                        led_cnt <= '0;
                        ch_cnt  <= '0;
                    end
                end
                ST_LOAD, ST_STREAM: begin
                    if (state == ST_STREAM && px_ready && px_last) begin
                        px_valid   <= 1'b0;
                        px_last    <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= ST_ADVANCE;
                    end else if (state == ST_LOAD || px_ready) begin
                        px_valid <= 1'b1;
                        px_data  <= lerp_y;
                        px_last  <= at_last;
                        state    <= ST_STREAM;
                        if (at_last) begin
                            led_cnt <= '0;
                            ch_cnt  <= '0;
                        end else if (ch_cnt == CH_LAST) begin
                            ch_cnt  <= '0;
                            led_cnt <= led_cnt + 1'b1;
                        end else begin
                            ch_cnt  <= ch_cnt + 1'b1;
                        end
                    end
                end
                ST_ADVANCE: begin
                    phase   <= phase + 1'b1;
                    busy    <= 1'b0;
                    led_cnt <= '0;
                    ch_cnt  <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_milestone_fader.sv
// Scoreboard bench for milestone_fader: a 5-LED GRB instance and a 1-LED GRBW
// instance with eight interpolation steps.
module tb_milestone_fader;

    typedef struct packed {
        logic       dc;
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N;
    logic        frame_start, ms_wr_en, px_ready;
    logic [23:0] ms_wr_data;
    logic        px_valid, px_last, busy, frame_done;
    logic [7:0]  px_data;

    logic        fs_b, wr_en_b, ready_b;
    logic [31:0] wr_data_b;
    logic        valid_b, last_b, busy_b, done_b;
    logic [7:0]  data_b;

    milestone_fader #(.LEDS(5), .INTERP(4), .CHANNELS(3), .COLOR_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .frame_start(frame_start), .ms_wr_en(ms_wr_en),
        .ms_wr_data(ms_wr_data), .px_valid(px_valid), .px_ready(px_ready),
        .px_data(px_data), .px_last(px_last), .busy(busy), .frame_done(frame_done)
    );

    milestone_fader #(.LEDS(1), .INTERP(8), .CHANNELS(4), .COLOR_W(8)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .frame_start(fs_b), .ms_wr_en(wr_en_b),
        .ms_wr_data(wr_data_b), .px_valid(valid_b), .px_ready(ready_b),
        .px_data(data_b), .px_last(last_b), .busy(busy_b), .frame_done(done_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    exp_t q1[$];
    exp_t q2[$];
    int xfer1 = 0, fd1 = 0, xfer2 = 0, fd2 = 0;
    int first_v_cyc = -1, fd_cyc = -1;
    logic pv_prev = 1'b0, pr_prev = 1'b0, pl_prev = 1'b0;
    logic [7:0] pd_prev = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the 5-LED instance: pops one expectation per transfer and
    // checks that a stalled byte is held.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            if (px_valid && pv_prev && !pr_prev) begin
                check("hold_data", px_data, pd_prev);
                check("hold_last", px_last, pl_prev);
            end
            if (px_valid && !pv_prev) first_v_cyc = cyc;
            if (px_valid && px_ready) begin
                tests++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL extra_byte: got %0h with no byte expected", px_data);
                end else begin
                    tests--;
                    e = q1.pop_front();
                    if (!e.dc) check("px_data", px_data, e.data);
                    check("px_last", px_last, e.last);
                end
                xfer1++;
            end
            if (frame_done) begin
                fd1++;
                fd_cyc = cyc;
            end
        end
        pv_prev = px_valid;
        pr_prev = px_ready;
        pd_prev = px_data;
        pl_prev = px_last;
    end

    // Monitor for the 1-LED GRBW instance.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            if (valid_b && ready_b) begin
                tests++;
                if (q2.size() == 0) begin
                    fails++;
                    $display("FAIL extra_byte_b: got %0h with no byte expected", data_b);
                end else begin
                    tests--;
                    e = q2.pop_front();
                    if (!e.dc) check("px_data_b", data_b, e.data);
                    check("px_last_b", last_b, e.last);
                end
                xfer2++;
            end
            if (done_b) fd2++;
        end
    end

    task automatic push_frame1(input logic dc, input logic [7:0] l0, l1, l2, l3, l4);
        logic [7:0] v[5];
        exp_t e;
        v = '{l0, l1, l2, l3, l4};
        for (int led = 0; led < 5; led++)
            for (int ch = 0; ch < 3; ch++) begin
                e.dc = dc; e.last = (led == 4 && ch == 2); e.data = v[led];
                q1.push_back(e);
            end
    endtask

    task automatic push_frame2(input logic dc, input logic [7:0] v);
        exp_t e;
        for (int ch = 0; ch < 4; ch++) begin
            e.dc = dc; e.last = (ch == 3); e.data = v;
            q2.push_back(e);
        end
    endtask

    task automatic wr1(input logic [23:0] d);
        @(posedge CLK); #1 ms_wr_en = 1'b1; ms_wr_data = d;
        @(posedge CLK); #1 ms_wr_en = 1'b0;
    endtask

    task automatic wr2(input logic [31:0] d);
        @(posedge CLK); #1 wr_en_b = 1'b1; wr_data_b = d;
        @(posedge CLK); #1 wr_en_b = 1'b0;
    endtask

    task automatic wait_done1(input int start);
        int n = 0;
        while (fd1 == start && n < 300) begin
            @(negedge CLK); #1;
            n++;
        end
        tests++;
        if (fd1 == start) begin
            fails++;
            $display("FAIL frame_timeout: got no frame_done, required one within 300 cycles");
        end
    endtask

    task automatic frame1();
        int s;
        s = fd1;
        @(posedge CLK); #1 frame_start = 1'b1;
        @(posedge CLK); #1 frame_start = 1'b0;
        wait_done1(s);
        repeat (2) @(posedge CLK);
        #1;
        check("frame_done_count", fd1, s + 1);
        check("frame_bytes_left", q1.size(), 0);
        check("busy_after", busy, 1'b0);
    endtask

    task automatic frame2();
        int s, n;
        s = fd2; n = 0;
        @(posedge CLK); #1 fs_b = 1'b1;
        @(posedge CLK); #1 fs_b = 1'b0;
        while (fd2 == s && n < 100) begin
            @(negedge CLK); #1;
            n++;
        end
        check("frame_done_count_b", fd2, s + 1);
        check("frame_bytes_left_b", q2.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, t, n;
        RST_N = 1'b0; frame_start = 1'b0; ms_wr_en = 1'b0; ms_wr_data = '0; px_ready = 1'b1;
        fs_b = 1'b0; wr_en_b = 1'b0; wr_data_b = '0; ready_b = 1'b1;
        #12;
        check("rst_px_valid", px_valid, 1'b0);
        check("rst_px_data", px_data, 8'h00);
        check("rst_px_last", px_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_px_valid_b", valid_b, 1'b0);
        #5 RST_N = 1'b1;

        // Build milestones ms0=000000, ms1=404040, ms2=404040 over 12 frames.
        wr1(24'h404040);
        for (int f = 0; f < 8; f++) begin
            push_frame1(1'b1, 0, 0, 0, 0, 0);
            frame1();
        end
        wr1(24'h000000);
        for (int f = 0; f < 4; f++) begin
            push_frame1(1'b1, 0, 0, 0, 0, 0);
            frame1();
        end

        // Phase 0 gradient with a 3-cycle stall on byte 4.
        push_frame1(1'b0, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40);
        s = xfer1;
        fork
            frame1();
            begin
                n = 0;
                while (xfer1 < s + 3 && n < 100) begin
                    @(negedge CLK); #1;
                    n++;
                end
                @(posedge CLK); #1 px_ready = 1'b0;
                @(posedge CLK); #1;
                check("stall_data", px_data, 8'h10);
                check("stall_valid", px_valid, 1'b1);
                repeat (2) @(posedge CLK);
                #1 px_ready = 1'b1;
            end
        join
        check("stall_transfers", xfer1, s + 15);

        // Phase 1 frame: latency, throughput and an ignored frame_start.
        wr1(24'hFFFFFF);
        push_frame1(1'b0, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40);
        s = fd1;
        @(posedge CLK); #1 frame_start = 1'b1; t = cyc;
        @(posedge CLK); #1 frame_start = 1'b0;
        repeat (4) @(posedge CLK);
        #1 frame_start = 1'b1;
        @(posedge CLK); #1 frame_start = 1'b0;
        wait_done1(s);
        check("latency_valid", first_v_cyc, t + 2);
        check("latency_done", fd_cyc, t + 17);
        repeat (3) @(posedge CLK);
        #1;
        check("ignored_start_valid", px_valid, 1'b0);
        check("ignored_start_busy", busy, 1'b0);
        check("ignored_start_done", fd1, s + 1);
        check("phase1_bytes_left", q1.size(), 0);

        // Phases 2 and 3, then the staged FFFFFF arrives in ms0.
        for (int f = 0; f < 2; f++) begin
            push_frame1(1'b1, 0, 0, 0, 0, 0);
            frame1();
        end
        push_frame1(1'b0, 8'hFF, 8'hBF, 8'h7F, 8'h3F, 8'h00);
        frame1();

        // Reset in the middle of a frame, after byte 7.
        push_frame1(1'b1, 0, 0, 0, 0, 0);
        s = xfer1;
        @(posedge CLK); #1 frame_start = 1'b1;
        @(posedge CLK); #1 frame_start = 1'b0;
        n = 0;
        while (xfer1 < s + 7 && n < 100) begin
            @(negedge CLK); #1;
            n++;
        end
        check("bytes_before_reset", xfer1, s + 7);
        @(posedge CLK); #2 RST_N = 1'b0;
        #1;
        check("abort_px_valid", px_valid, 1'b0);
        check("abort_px_data", px_data, 8'h00);
        check("abort_px_last", px_last, 1'b0);
        check("abort_busy", busy, 1'b0);
        q1.delete();
        #20;
        @(negedge CLK); RST_N = 1'b1;
        push_frame1(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        frame1();

        // GRBW, eight steps, one LED: shift every 8th frame, midpoint blend.
        wr2(32'hFFFFFFFF);
        for (int f = 1; f <= 7; f++) begin
            push_frame2(1'b1, 8'h00);
            frame2();
        end
        push_frame2(1'b0, 8'h00);
        frame2();
        push_frame2(1'b0, 8'hFF);
        frame2();
        wr2(32'h00000000);
        for (int f = 10; f <= 16; f++) begin
            push_frame2(1'b1, 8'h00);
            frame2();
        end
        push_frame2(1'b0, 8'h00);
        frame2();
        for (int f = 18; f <= 20; f++) begin
            push_frame2(1'b1, 8'h00);
            frame2();
        end
        push_frame2(1'b0, 8'h7F);
        frame2();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
